d_shift_reg: RTL
================

D_SHIFT_REG -- requirements
Module: d_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port R  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port D  input  WIDTH  parallel load data.
REQ-006 SHALL have port mode  input  3  operation select, sampled each rising edge.
REQ-007 SHALL have port sin  input  1  serial input bit for shift modes.
REQ-008 SHALL have port Q  output  WIDTH  registered register contents.
REQ-009 SHALL have port q  output  WIDTH  bitwise complement of Q, always ~Q.
REQ-010 SHALL have port sout  output  1  registered bit most recently shifted or rotated out.
REQ-011 SHALL have port cnt  output  clog2(WIDTH+1)  loaded bits not yet shifted out.
REQ-012 SHALL have port drained  output  1  high when cnt==0, combinational from cnt.

Function
REQ-013 SHALL decode mode: 000 hold, 001 load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 clear, 111 hold.
REQ-014 SHALL perform every mode update at one rising edge; results visible on Q one cycle after mode is sampled.
REQ-015 Load SHALL set Q=D and cnt=WIDTH; sout unchanged.
REQ-016 Shift left SHALL set Q={Q[WIDTH-2:0],sin} and sout=old Q[WIDTH-1].
REQ-017 Shift right SHALL set Q={sin,Q[WIDTH-1:1]} and sout=old Q[0].
REQ-018 Either shift SHALL decrement cnt by 1, saturating at 0 with no wrap.
REQ-019 Rotate left/right SHALL circulate Q by one bit, set sout to the bit that wrapped, and leave cnt unchanged.
REQ-020 Clear SHALL set Q=0 and cnt=0; sout unchanged.
REQ-021 Hold modes SHALL leave Q, cnt, and sout unchanged.
REQ-022 A shift with cnt==0 SHALL still move Q and update sout; only cnt saturates.
REQ-023 q SHALL track Q combinationally with no cycle delay.

Reset
REQ-024 With R=1 at a rising edge: Q=RESET_VAL, q=~RESET_VAL, cnt=0, drained=1, sout=0.
REQ-025 R SHALL take priority over any mode in the same cycle, including load issued mid-sequence.
REQ-026 R SHALL have no effect between clock edges, i.e. no asynchronous path.

Configuration
REQ-027 When macro D_SHIFT_REG_PARITY_EN is defined, SHALL add output port par (1 bit) = XOR-reduction of Q, combinational.
REQ-028 When D_SHIFT_REG_PARITY_EN is undefined, port par and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8, RESET_VAL=0)
REQ-029 R=1 for one edge with mode=001, D=FF -> Q=00, q=FF, cnt=0, drained=1, sout=0.
REQ-030 Load with D=A5 -> next edge Q=A5, q=5A, cnt=8, drained=0.
REQ-031 After load A5, shift left 8 edges with sin=0 -> sout sequence 1,0,1,0,0,1,0,1; Q=00; cnt=0 and drained=1 after the 8th edge; a 9th shift leaves cnt=0.
REQ-032 Q=81, cnt=5, rotate right -> Q=C0, sout=1, cnt=5; rotate left from 81 -> Q=03, sout=1.
REQ-033 After load 3C, shift right 3 edges with sin=1, then R=1 -> Q=E7, cnt=5 before reset; all reset values after the R edge.
REQ-034 With D_SHIFT_REG_PARITY_EN defined, Q=07 -> par=1 and Q=0F -> par=0; without the macro the bench compiles without par.

Source files
------------

// File: rtl/d_shift_reg.sv
// rtl/d_shift_reg.sv - mode-selected shift/rotate/load register with drain counter
// Optional parity output enabled by defining D_SHIFT_REG_PARITY_EN.
module d_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         R,
  input  logic [WIDTH-1:0]             D,
  input  logic [2:0]                   mode,
  input  logic                         sin,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             q,
  output logic                         sout,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         drained
`ifdef D_SHIFT_REG_PARITY_EN
  ,
  output logic                         par
`endif
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_CLR   = 3'b110,
    M_HOLD2 = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_dec;
  logic             sout_next;

  // Shifts count down the loaded bits but never wrap below zero.
  assign cnt_dec = (cnt == '0) ? '0 : cnt - CW'(1);

  always_comb begin
    q_next    = Q;
    cnt_next  = cnt;
    sout_next = sout;
    case (mode_t'(mode))
      M_LOAD: begin
        q_next   = D;
        cnt_next = CW'(WIDTH);
      end
      M_SHL: begin
        q_next    = {Q[WIDTH-2:0], sin};
        sout_next = Q[WIDTH-1];
        cnt_next  = cnt_dec;
      end
      M_SHR: begin
        q_next    = {sin, Q[WIDTH-1:1]};
        sout_next = Q[0];
        cnt_next  = cnt_dec;
      end
      M_ROL: begin
        q_next    = {Q[WIDTH-2:0], Q[WIDTH-1]};
        sout_next = Q[WIDTH-1];
      end
      M_ROR: begin
        q_next    = {Q[0], Q[WIDTH-1:1]};
        sout_next = Q[0];
      end
      M_CLR: begin
        q_next   = '0;
        cnt_next = '0;
      end
      default: begin
        q_next    = Q;
        cnt_next  = cnt;
        sout_next = sout;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      Q    <= RESET_VAL;
      cnt  <= '0;
      sout <= 1'b0;
    end else begin
      Q    <= q_next;
      cnt  <= cnt_next;
      sout <= sout_next;
    end
  end

  assign q       = ~Q;
  assign drained = (cnt == '0);

`ifdef D_SHIFT_REG_PARITY_EN
  assign par = ^Q;
`endif

endmodule
